// File: rtl/nnlut_coef_loader.sv
// Writer side of the NN-LUT coefficient tables. A framed word stream
// (header, breakpoints, slopes, intercepts, checksum) is collected into
// shadow banks, validated, then copied to the active banks in one cycle.
module nnlut_coef_loader #(
  parameter int          x_WIDTH = 8,
  parameter int          k_WIDTH = 32,
  parameter int          b_WIDTH = 32,
  parameter int          bp_NUM  = 16,
  parameter logic [15:0] MAGIC   = 16'hC0EF
) (
  input  logic                        clk_p,
  input  logic                        rst_n,
  input  logic [31:0]                 in_data,
  input  logic                        in_valid_n,
  output logic                        in_ready,
  input  logic                        abort,
  input  logic                        commit_hold,
  output logic [bp_NUM*x_WIDTH-1:0]   bp_flat,
  output logic [bp_NUM*k_WIDTH-1:0]   k_flat,
  output logic [bp_NUM*b_WIDTH-1:0]   b_flat,
  output logic                        tbl_valid,
  output logic                        load_busy,
  output logic                        load_done,
  output logic                        load_err
);

  localparam int              CNT_W    = $clog2(bp_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(bp_NUM - 1);
  localparam logic [7:0]      NUM8     = 8'(bp_NUM);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BP     = 3'd1;
  localparam logic [2:0] S_K      = 3'd2;
  localparam logic [2:0] S_B      = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      chk;
  logic             mono_bad;
  logic             accept;
  logic             cnt_last;
  logic             do_commit;
  logic             hdr_ok;
  logic signed [x_WIDTH-1:0] new_bp;

  logic signed [x_WIDTH-1:0] shadow_bp [bp_NUM];
  logic        [k_WIDTH-1:0] shadow_k  [bp_NUM];
  logic        [b_WIDTH-1:0] shadow_b  [bp_NUM];

  // Handshake and status decode; abort drops any word presented with it
  always_comb begin
    in_ready  = (state == S_IDLE) || (state == S_BP) || (state == S_K) ||
                (state == S_B)    || (state == S_CHK);
    accept    = !in_valid_n && in_ready && !abort;
    cnt_last  = (cnt == CNT_LAST);
    do_commit = (state == S_COMMIT) && !commit_hold;
    hdr_ok    = (in_data[31:16] == MAGIC) && (in_data[7:0] == NUM8);
    new_bp    = $signed(in_data[x_WIDTH-1:0]);
    load_busy = (state != S_IDLE);
    load_done = do_commit;
  end

  // Frame sequencing, running checksum, monotonicity and error flag
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      chk      <= '0;
      mono_bad <= 1'b0;
      load_err <= 1'b0;
    end else if (abort && (state != S_COMMIT)) begin
      state    <= S_IDLE;
      cnt      <= '0;
      chk      <= '0;
      mono_bad <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (hdr_ok) begin
              load_err <= 1'b0;
              chk      <= in_data;
              cnt      <= '0;
              mono_bad <= 1'b0;
              state    <= S_BP;
            end else begin
              load_err <= 1'b1;
            end
          end
        end
        S_BP, S_K, S_B: begin
          if (accept) begin
            chk <= chk ^ in_data;
            if ((state == S_BP) && (cnt != '0) && (new_bp <= shadow_bp[cnt - 1'b1]))
              mono_bad <= 1'b1;
            if (cnt_last) begin
              cnt   <= '0;
              state <= (state == S_BP) ? S_K : (state == S_K) ? S_B : S_CHK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_CHK: begin
          if (accept) begin
            if ((in_data == chk) && !mono_bad) begin
              state <= S_COMMIT;
            end else begin
              load_err <= 1'b1;
              state    <= S_ERR;
            end
          end
        end
        S_COMMIT: begin
          if (!commit_hold) state <= S_IDLE;
        end
        S_ERR: begin
          load_err <= 1'b1;
          mono_bad <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shadow banks: filled word by word, wiped when a frame is rejected
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < bp_NUM; i++) begin
        shadow_bp[i] <= '0;
        shadow_k[i]  <= '0;
        shadow_b[i]  <= '0;
      end
    end else if (state == S_ERR) begin
      for (int unsigned i = 0; i < bp_NUM; i++) begin
        shadow_bp[i] <= '0;
        shadow_k[i]  <= '0;
        shadow_b[i]  <= '0;
      end
    end else if (accept) begin
      case (state)
        S_BP:    shadow_bp[cnt] <= new_bp;
        S_K:     shadow_k[cnt]  <= in_data[k_WIDTH-1:0];
        S_B:     shadow_b[cnt]  <= in_data[b_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Active banks: whole-table copy in the single commit cycle
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      bp_flat   <= '0;
      k_flat    <= '0;
      b_flat    <= '0;
      tbl_valid <= 1'b0;
    end else if (do_commit) begin
      for (int unsigned i = 0; i < bp_NUM; i++) begin
        bp_flat[i*x_WIDTH +: x_WIDTH] <= shadow_bp[i];
        k_flat[i*k_WIDTH +: k_WIDTH]  <= shadow_k[i];
        b_flat[i*b_WIDTH +: b_WIDTH]  <= shadow_b[i];
      end
      tbl_valid <= 1'b1;
    end
  end

endmodule
